// File: rtl/map_ss_pkg.sv
// Shared definitions for the mapper save-state sequencer.
package map_ss_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_SRD,
      ST_WFETCH,
      ST_WHOLD,
      ST_NEXT,
      ST_DONE
   } ss_state_e;

   localparam int          SS_LEN_DEF = 128;
   localparam logic [7:0]  MAP_IDX    = 8'd127;

endpackage

// File: rtl/map_ss_seq_if.sv
// Host, state-buffer and mapper save-state signals of map_ss_seq.
interface map_ss_seq_if;

   logic       cmd_req;
   logic       cmd_wr;
   logic       cmd_ack;
   logic       busy;
   logic       err;
   logic [7:0] buf_addr;
   logic [7:0] buf_rd;
   logic [7:0] buf_wd;
   logic       buf_we;
   logic       m2_fall;
   logic       ss_act;
   logic       ss_we;
   logic [7:0] ss_addr;
   logic [7:0] ss_wdat;
   logic [7:0] ss_rdat;

   modport master (
      output cmd_req, cmd_wr, buf_rd, m2_fall, ss_rdat,
      input  cmd_ack, busy, err, buf_addr, buf_wd, buf_we,
             ss_act, ss_we, ss_addr, ss_wdat
   );

   modport slave (
      input  cmd_req, cmd_wr, buf_rd, m2_fall, ss_rdat,
      output cmd_ack, busy, err, buf_addr, buf_wd, buf_we,
             ss_act, ss_we, ss_addr, ss_wdat
   );

endinterface

// File: rtl/ss_tmo.sv
// Wait-timeout down-counter: reloads on clr, counts while en, expire pulses at terminal count.
module ss_tmo #(
   parameter int TMO_CYC = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam int            CW      = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
   localparam logic [CW-1:0] TC_LOAD = CW'(TMO_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= TC_LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/map_ss_seq.sv
// Mapper save-state sequencer: walks SS_LEN register indices between mapper and state buffer.
// Optional wait timeout on ARM/WHOLD is built in with `define SS_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for cmd_req, outputs quiet
// ARM     | save-state mode on, waiting for first m2_fall
// SRD     | copy mapper register idx into buffer (one buf_we)
// WFETCH  | two cycles: present buf_addr, then capture buf_rd into ss_wdat
// WHOLD   | ss_we high until one m2_fall latches the write
// NEXT    | advance idx or finish
// DONE    | cmd_ack pulse, save-state mode off
module map_ss_seq
   import map_ss_pkg::*;
#(
   parameter int SS_LEN  = SS_LEN_DEF,
   parameter int TMO_CYC = 4096
) (
   input  logic         clk,
   input  logic         rst,
   map_ss_seq_if.slave  bus
);

   if ((SS_LEN < 1) || (SS_LEN > 256) || (TMO_CYC < 1)) begin : g_bad_param
      $error("map_ss_seq: SS_LEN or TMO_CYC out of range");
   end

   localparam logic [7:0] IDX_LAST = 8'(SS_LEN - 1);

   ss_state_e  state, state_nxt;
   logic [7:0] idx, idx_nxt;
   logic       wr_q, wr_nxt;
   logic       fetch_ph, fetch_ph_nxt;
   logic [7:0] wdat_q, wdat_nxt;
   logic       tmo_exp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         idx      <= 8'd0;
         wr_q     <= 1'b0;
         fetch_ph <= 1'b0;
         wdat_q   <= 8'd0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         wr_q     <= wr_nxt;
         fetch_ph <= fetch_ph_nxt;
         wdat_q   <= wdat_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      wr_nxt       = wr_q;
      fetch_ph_nxt = fetch_ph;
      wdat_nxt     = wdat_q;
      case (state)
         ST_IDLE: begin
            if (bus.cmd_req) begin
               wr_nxt    = bus.cmd_wr;
               idx_nxt   = 8'd0;
               state_nxt = ST_ARM;
            end
         end
         ST_ARM: begin
            if (bus.m2_fall) begin
               fetch_ph_nxt = 1'b0;
               state_nxt    = wr_q ? ST_WFETCH : ST_SRD;
            end else if (tmo_exp) begin
               state_nxt = ST_DONE;
            end
         end
         ST_SRD: begin
            state_nxt = ST_NEXT;
         end
         ST_WFETCH: begin
            // Registered RAM: data for buf_addr shows up one cycle later.
            if (!fetch_ph) begin
               fetch_ph_nxt = 1'b1;
            end else begin
               fetch_ph_nxt = 1'b0;
               wdat_nxt     = bus.buf_rd;
               state_nxt    = ST_WHOLD;
            end
         end
         ST_WHOLD: begin
            if (bus.m2_fall) begin
               state_nxt = ST_NEXT;
            end else if (tmo_exp) begin
               state_nxt = ST_DONE;
            end
         end
         ST_NEXT: begin
            if (idx == IDX_LAST) begin
               state_nxt = ST_DONE;
            end else begin
               idx_nxt      = idx + 8'd1;
               fetch_ph_nxt = 1'b0;
               state_nxt    = wr_q ? ST_WFETCH : ST_SRD;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.ss_act   = (state != ST_IDLE) && (state != ST_DONE);
   assign bus.ss_we    = (state == ST_WHOLD);
   assign bus.ss_addr  = bus.ss_act ? idx : 8'd0;
   assign bus.ss_wdat  = wdat_q;
   assign bus.buf_we   = (state == ST_SRD);
   assign bus.buf_wd   = (state == ST_SRD) ? bus.ss_rdat : 8'd0;
   assign bus.buf_addr = ((state == ST_SRD) || (state == ST_WFETCH)) ? idx : 8'd0;
   assign bus.cmd_ack  = (state == ST_DONE);
   assign bus.busy     = (state != ST_IDLE);

`ifdef SS_TIMEOUT_EN
   logic tmo_en;
   logic err_q;

   assign tmo_en = (state == ST_ARM) || (state == ST_WHOLD);

   ss_tmo #(
      .TMO_CYC (TMO_CYC)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .en     (tmo_en),
      .clr    (!tmo_en),
      .expire (tmo_exp)
   );

   // m2_fall on the expiring cycle wins, so err only marks a real timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if ((state == ST_IDLE) && bus.cmd_req) begin
         err_q <= 1'b0;
      end else if (tmo_exp && !bus.m2_fall) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign tmo_exp = 1'b0;
   assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_map_ss_seq.sv
// Bench for map_ss_seq: table of save/restore vectors plus hand-written corner sequences.
module tb_map_ss_seq;

   typedef struct {
      bit          wr;
      int          per;
      logic [23:0] src;
      logic [23:0] exp;
      int          exp_we;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } xfer_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   map_ss_seq_if bus3 ();
   map_ss_seq_if bus128 ();

   map_ss_seq #(.SS_LEN(3), .TMO_CYC(16)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   map_ss_seq #(.SS_LEN(128), .TMO_CYC(16)) u_dut128 (
      .clk (clk),
      .rst (rst),
      .bus (bus128)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   bit   m2_en  = 1'b0;
   int   m2_per = 20;
   int   m2_cnt = 0;
   logic m2     = 1'b0;

   logic [7:0] mem3 [256];
   logic [7:0] map3 [256];
   xfer_t      sb3 [$];
   xfer_t      sb128 [$];

   int   ack3 = 0, bwe3 = 0, swe3 = 0, overlap = 0;
   int   first_m2 = -1, arm_cyc = -1, ack_cyc = -1;
   logic ack_err = 1'b0, ack_act = 1'b0;
   int   ack128 = 0, bwe128 = 0, first_m2_128 = -1, ack_cyc128 = -1, max_addr128 = 0;

   vec_t vecs [5];

   assign bus3.ss_rdat   = map3[bus3.ss_addr];
   assign bus3.m2_fall   = m2;
   assign bus128.ss_rdat = bus128.ss_addr ^ 8'h5A;
   assign bus128.m2_fall = m2;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic pop_chk(input bit big, input logic [7:0] a, input logic [7:0] d, input string tag);
      xfer_t x;
      if (big ? (sb128.size() == 0) : (sb3.size() == 0)) begin
         chk({tag, "_unexpected_xfer"}, int'(a), -1);
      end else begin
         x = big ? sb128.pop_front() : sb3.pop_front();
         chk({tag, "_addr"}, int'(a), int'(x.addr));
         chk({tag, "_data"}, int'(d), int'(x.data));
      end
   endtask

   // m2_fall generator: one-clk pulse every m2_per clocks while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (m2_en) begin
            if (m2_cnt >= m2_per - 1) begin
               m2     = 1'b1;
               m2_cnt = 0;
            end else begin
               m2     = 1'b0;
               m2_cnt++;
            end
         end else begin
            m2     = 1'b0;
            m2_cnt = 0;
         end
      end
   end

   // Registered state-buffer read port for the 3-entry instance.
   initial begin
      logic [7:0] a;
      bus3.buf_rd = 8'h00;
      forever begin
         @(negedge clk);
         a = bus3.buf_addr;
         @(posedge clk);
         #1 bus3.buf_rd = mem3[a];
      end
   end

   // Monitor: buffer writes, mapper latches, acks, timing marks.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (bus3.busy && (arm_cyc < 0)) arm_cyc = cyc;
         if (bus3.busy && m2 && (first_m2 < 0)) first_m2 = cyc;
         if (bus3.buf_we) begin
            bwe3++;
            mem3[bus3.buf_addr] = bus3.buf_wd;
            pop_chk(1'b0, bus3.buf_addr, bus3.buf_wd, "buf_wr");
         end
         if (m2 && bus3.ss_we) begin
            swe3++;
            map3[bus3.ss_addr] = bus3.ss_wdat;
            pop_chk(1'b0, bus3.ss_addr, bus3.ss_wdat, "map_wr");
         end
         if (bus3.ss_we && bus3.buf_we) overlap++;
         if (bus128.ss_we && bus128.buf_we) overlap++;
         if (bus3.cmd_ack) begin
            ack3++;
            ack_cyc = cyc;
            ack_err = bus3.err;
            ack_act = bus3.ss_act;
         end
         if (bus128.busy && m2 && (first_m2_128 < 0)) first_m2_128 = cyc;
         if (bus128.ss_act && (int'(bus128.ss_addr) > max_addr128)) max_addr128 = int'(bus128.ss_addr);
         if (bus128.buf_we) begin
            bwe128++;
            pop_chk(1'b1, bus128.buf_addr, bus128.buf_wd, "big_wr");
         end
         if (bus128.cmd_ack) begin
            ack128++;
            ack_cyc128 = cyc;
         end
      end
   end

   task automatic load3(input bit wr, input logic [23:0] src);
      for (int i = 0; i < 256; i++) begin
         mem3[i] = 8'h00;
         map3[i] = 8'h00;
      end
      sb3.delete();
      for (int i = 0; i < 3; i++) begin
         xfer_t x;
         x.addr = 8'(i);
         x.data = src[8*i +: 8];
         if (wr) mem3[i] = x.data;
         else    map3[i] = x.data;
         sb3.push_back(x);
      end
   endtask

   task automatic start3(input bit wr);
      @(posedge clk);
      #1;
      first_m2 = -1;
      arm_cyc  = -1;
      ack_cyc  = -1;
      ack3 = 0;
      bwe3 = 0;
      swe3 = 0;
      bus3.cmd_req = 1'b1;
      bus3.cmd_wr  = wr;
      @(posedge clk);
      #1 bus3.cmd_req = 1'b0;
   endtask

   task automatic wait_ack3(input int budget, input string name);
      int n = 0;
      while ((ack3 == 0) && (n < budget)) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({name, "_ack_in_time"}, int'(ack3 != 0), 1);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic wait_whold_idx1(input string name);
      bit ok = 1'b0;
      for (int n = 0; (n < 500) && !ok; n++) begin
         @(negedge clk);
         #1;
         if (bus3.ss_we && (bus3.ss_addr == 8'd1)) ok = 1'b1;
      end
      chk({name, "_whold_idx1_seen"}, int'(ok), 1);
   endtask

   task automatic check_dest3(input string tag, input bit wr, input logic [23:0] exp);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_dest%0d", tag, i), int'(wr ? map3[i] : mem3[i]), int'(exp[8*i +: 8]));
      end
   endtask

   task automatic chk_reset3(input string tag);
      chk({tag, "_ss_act"},   int'(bus3.ss_act),   0);
      chk({tag, "_ss_we"},    int'(bus3.ss_we),    0);
      chk({tag, "_ss_addr"},  int'(bus3.ss_addr),  0);
      chk({tag, "_ss_wdat"},  int'(bus3.ss_wdat),  0);
      chk({tag, "_buf_we"},   int'(bus3.buf_we),   0);
      chk({tag, "_buf_wd"},   int'(bus3.buf_wd),   0);
      chk({tag, "_buf_addr"}, int'(bus3.buf_addr), 0);
      chk({tag, "_cmd_ack"},  int'(bus3.cmd_ack),  0);
      chk({tag, "_busy"},     int'(bus3.busy),     0);
      chk({tag, "_err"},      int'(bus3.err),      0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{wr: 1'b0, per: 20, src: 24'h010A05, exp: 24'h010A05, exp_we: 3, exp_lat: 7};
      vecs[1] = '{wr: 1'b1, per: 20, src: 24'h010F06, exp: 24'h010F06, exp_we: 3, exp_lat: -1};
      vecs[2] = '{wr: 1'b0, per: 1,  src: 24'h8000FF, exp: 24'h8000FF, exp_we: 3, exp_lat: 7};
      vecs[3] = '{wr: 1'b1, per: 1,  src: 24'h3C5AA5, exp: 24'h3C5AA5, exp_we: 3, exp_lat: -1};
      vecs[4] = '{wr: 1'b0, per: 7,  src: 24'h123456, exp: 24'h123456, exp_we: 3, exp_lat: 7};

      bus3.cmd_req   = 1'b0;
      bus3.cmd_wr    = 1'b0;
      bus128.cmd_req = 1'b0;
      bus128.cmd_wr  = 1'b0;
      bus128.buf_rd  = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem3[i] = 8'h00;
         map3[i] = 8'h00;
      end

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk_reset3("por");
      chk("por_big_ss_act", int'(bus128.ss_act), 0);
      chk("por_big_busy", int'(bus128.busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         string tag;
         tag = $sformatf("v%0d", v);
         load3(vecs[v].wr, vecs[v].src);
         m2_per = vecs[v].per;
         m2_en  = 1'b1;
         start3(vecs[v].wr);
         wait_ack3(2000, tag);
         chk({tag, "_ack_count"}, ack3, 1);
         chk({tag, "_act_at_ack"}, int'(ack_act), 0);
         chk({tag, "_we_count"}, vecs[v].wr ? swe3 : bwe3, vecs[v].exp_we);
         chk({tag, "_other_we"}, vecs[v].wr ? bwe3 : swe3, 0);
         chk({tag, "_sb_left"}, sb3.size(), 0);
         check_dest3(tag, vecs[v].wr, vecs[v].exp);
         chk({tag, "_busy_after"}, int'(bus3.busy), 0);
         chk({tag, "_err_after"}, int'(bus3.err), 0);
         if (vecs[v].exp_lat >= 0) chk({tag, "_latency"}, ack_cyc - first_m2, vecs[v].exp_lat);
      end

      // cmd_req while holding a mapper write must not restart the walk.
      load3(1'b1, 24'h332211);
      m2_per = 20;
      start3(1'b1);
      wait_whold_idx1("ign");
      @(posedge clk);
      #1;
      bus3.cmd_req = 1'b1;
      bus3.cmd_wr  = 1'b0;
      @(posedge clk);
      #1 bus3.cmd_req = 1'b0;
      wait_ack3(2000, "ign");
      chk("ign_ack_count", ack3, 1);
      chk("ign_map_writes", swe3, 3);
      chk("ign_buf_writes", bwe3, 0);
      chk("ign_sb_left", sb3.size(), 0);
      check_dest3("ign", 1'b1, 24'h332211);

      // Reset in the middle of a restore.
      load3(1'b1, 24'h665544);
      start3(1'b1);
      wait_whold_idx1("rst");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk_reset3("mid_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("mid_rst_no_ack", ack3, 0);
      load3(1'b0, 24'h998877);
      start3(1'b0);
      wait_ack3(2000, "post_rst");
      chk("post_rst_ack_count", ack3, 1);
      chk("post_rst_buf_writes", bwe3, 3);
      chk("post_rst_sb_left", sb3.size(), 0);
      check_dest3("post_rst", 1'b0, 24'h998877);

`ifdef SS_TIMEOUT_EN
      load3(1'b0, 24'h030201);
      sb3.delete();
      m2_en = 1'b0;
      start3(1'b0);
      wait_ack3(100, "tmo");
      chk("tmo_ack_delay", ack_cyc - arm_cyc, 16);
      chk("tmo_err_at_ack", int'(ack_err), 1);
      chk("tmo_no_buf_we", bwe3, 0);
      chk("tmo_err_sticky", int'(bus3.err), 1);
      chk("tmo_busy_after", int'(bus3.busy), 0);
      load3(1'b0, 24'h030201);
      m2_per = 5;
      m2_en  = 1'b1;
      start3(1'b0);
      @(negedge clk);
      #1;
      chk("tmo_err_cleared", int'(bus3.err), 0);
      wait_ack3(2000, "tmo_next");
      chk("tmo_next_ack_count", ack3, 1);
      chk("tmo_next_buf_writes", bwe3, 3);
      chk("tmo_next_err", int'(bus3.err), 0);
`else
      load3(1'b0, 24'h030201);
      m2_en = 1'b0;
      start3(1'b0);
      repeat (100) @(negedge clk);
      #1;
      chk("wait_no_ack", ack3, 0);
      chk("wait_busy", int'(bus3.busy), 1);
      chk("wait_ss_act", int'(bus3.ss_act), 1);
      chk("wait_err_low", int'(bus3.err), 0);
      chk("wait_no_buf_we", bwe3, 0);
      m2_per = 5;
      m2_en  = 1'b1;
      wait_ack3(2000, "wait_end");
      chk("wait_end_ack_count", ack3, 1);
      chk("wait_end_buf_writes", bwe3, 3);
      chk("wait_end_sb_left", sb3.size(), 0);
      check_dest3("wait_end", 1'b0, 24'h030201);
`endif

      // Full-length walk on the 128-entry instance.
      sb128.delete();
      for (int i = 0; i < 128; i++) begin
         xfer_t x;
         x.addr = 8'(i);
         x.data = 8'(i) ^ 8'h5A;
         sb128.push_back(x);
      end
      m2_per = 5;
      m2_en  = 1'b1;
      @(posedge clk);
      #1;
      ack128 = 0;
      bwe128 = 0;
      first_m2_128 = -1;
      max_addr128 = 0;
      bus128.cmd_req = 1'b1;
      bus128.cmd_wr  = 1'b0;
      @(posedge clk);
      #1 bus128.cmd_req = 1'b0;
      begin
         int n = 0;
         while ((ack128 == 0) && (n < 2000)) begin
            @(negedge clk);
            #1;
            n++;
         end
      end
      chk("big_ack_in_time", int'(ack128 != 0), 1);
      repeat (2) @(negedge clk);
      #1;
      chk("big_ack_count", ack128, 1);
      chk("big_buf_writes", bwe128, 128);
      chk("big_max_addr", max_addr128, 127);
      chk("big_sb_left", sb128.size(), 0);
      chk("big_latency", ack_cyc128 - first_m2_128, 257);
      chk("big_busy_after", int'(bus128.busy), 0);

      chk("no_we_overlap", overlap, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/map_ss_seq.md
MAP_SS_SEQ -- requirements
Module: map_ss_seq

Interface
REQ-001 SHALL have parameter SS_LEN, default 128: number of save-state addresses walked, 0..SS_LEN-1, range 1..256.
REQ-002 SHALL have parameter TMO_CYC, default 4096: clk cycles allowed per m2_fall wait (used only with SS_TIMEOUT_EN).
REQ-003 SHALL have one clock and a synchronous, active-high reset, named as the codebase does:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
REQ-004 SHALL have these host-side ports:
- cmd_req  in  1  start strobe, sampled in IDLE
- cmd_wr  in  1  1 = restore (buffer to mapper), 0 = save (mapper to buffer); sampled with cmd_req
- cmd_ack  out  1  one-cycle pulse when the operation ends
- busy  out  1  high from accept until the cycle after cmd_ack
- err  out  1  timeout flag, sticky until the next accepted cmd_req
REQ-005 SHALL have these buffer-side ports:
- buf_addr  out  8  state-buffer address
- buf_rd  in  8  buffer read data, valid 1 clk after buf_addr (registered RAM)
- buf_wd  out  8  buffer write data
- buf_we  out  1  buffer write strobe
REQ-006 SHALL have these mapper-side ports:
- m2_fall  in  1  one-clk pulse per M2 falling edge, already synchronised to clk
- ss_act  out  1  mapper save-state mode
- ss_we  out  1  mapper save-state write
- ss_addr  out  8  mapper save-state register index
- ss_wdat  out  8  data presented on the mapper data bus during ss_we
- ss_rdat  in  8  mapper readback, combinational from ss_addr

Function
REQ-007 SHALL implement states IDLE, ARM, SRD, WFETCH, WHOLD, NEXT, DONE.
REQ-008 IDLE: cmd_req=1 SHALL latch cmd_wr, clear idx to 0 and err, and go to ARM; cmd_req while not in IDLE SHALL be ignored.
REQ-009 ARM: ss_act=1; the first m2_fall SHALL take the FSM to SRD if saving, WFETCH if restoring.
REQ-010 SRD: ss_addr=idx; buf_addr=idx; buf_wd=ss_rdat; buf_we=1 for exactly this one cycle; then go to NEXT.
REQ-011 WFETCH: buf_addr=idx for one cycle; next cycle SHALL register buf_rd into ss_wdat and go to WHOLD.
REQ-012 WHOLD: ss_we=1, ss_addr=idx, ss_wdat stable; the first m2_fall SHALL drop ss_we on the next clk and go to NEXT, so that exactly one mapper latch edge sees the write.
REQ-013 NEXT: if idx==SS_LEN-1 go to DONE, else idx+1 and return to SRD or WFETCH; idx SHALL be 8 bits and SHALL never wrap past SS_LEN-1.
REQ-014 DONE: cmd_ack=1 for one cycle, ss_act=0 in the same cycle, then go to IDLE.
REQ-015 ss_act SHALL be 1 in every state except IDLE and DONE.
REQ-016 ss_we and buf_we SHALL never be high in the same cycle.
REQ-017 Latency:
- save SHALL complete in (cycles to first m2_fall) + 2*SS_LEN + 1 clk
- restore SHALL take one m2_fall per address
REQ-018 m2_fall arriving in any state other than ARM or WHOLD SHALL be ignored.

Reset
REQ-019 rst SHALL force state IDLE and idx=0, and all outputs to 0: ss_act, ss_we, ss_addr, ss_wdat, buf_we, buf_wd, buf_addr, cmd_ack, busy, err.
REQ-020 rst mid-operation SHALL deassert ss_act and ss_we on the next clk edge and SHALL NOT issue cmd_ack.

Configuration
REQ-021 With SS_TIMEOUT_EN defined, a counter SHALL run in ARM and WHOLD; reaching TMO_CYC-1 without m2_fall SHALL set err=1 and go to DONE (ack issued, ss_we dropped).
REQ-022 Without SS_TIMEOUT_EN, ARM and WHOLD SHALL wait indefinitely, and err SHALL be tied to 0.

Structure
REQ-023 Package map_ss_pkg SHALL hold the state encoding, the SS_LEN default and the index 127 reserved for map_idx.
REQ-024 The timeout counter SHALL be sub-module ss_tmo (enable, clear, expire pulse), instantiated only under SS_TIMEOUT_EN.

Verification
REQ-025 Save, SS_LEN=3, mapper model returning {0x05,0x0A,0x01}, m2_fall every 20 clk -> buffer holds 05,0A,01; exactly 3 buf_we pulses; one cmd_ack.
REQ-026 Restore, SS_LEN=3, buffer {0x06,0x0F,0x01}, mapper model registering on m2_fall -> model prg=6, chr=0xF, mirror=1; ss_we high across exactly 3 m2_fall pulses.
REQ-027 cmd_req pulsed in WHOLD at idx=1 -> ignored; idx sequence 0,1,2 unchanged; a single cmd_ack.
REQ-028 rst asserted in WHOLD at idx=1 -> ss_act=0 and ss_we=0 next clk; no cmd_ack; a following save starts from idx 0.
REQ-029 SS_TIMEOUT_EN, TMO_CYC=16, no m2_fall -> err=1 and cmd_ack 16 clk after entering ARM; err cleared by the next accepted cmd_req.
REQ-030 SS_LEN=128 save -> ss_addr reaches 127 and then DONE; ss_addr never exceeds 127.
